// File: rtl/div_sequencer.sv
// Multi-cycle RV32M DIV/DIVU/REM/REMU sequencer: radix-2 restoring divide on magnitudes + sign fix.
// Optional DIV_ZERO_FAST_EN: a zero divisor short-circuits IDLE -> FIN.
module div_sequencer #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [4:0]       alu_op,
    input  logic [WIDTH-1:0] data1,
    input  logic [WIDTH-1:0] data2,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);
    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [2:0] {StIdle, StLoad, StCalc, StFix, StFin} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             is_signed_q, is_signed_d;
    logic             is_rem_q, is_rem_d;
    logic             sign1_q, sign1_d;
    logic             sign2_q, sign2_d;
    logic             dzero_q, dzero_d;

    logic             div_op;
    logic [WIDTH:0]   diff;
    logic             neg_quo;
    logic             neg_rem;

    assign div_op  = alu_op inside {5'b00101, 5'b00111, 5'b01101, 5'b01111};
    // Shifted partial remainder needs one extra bit for the trial subtract.
    assign diff    = {rem_q, quo_q[WIDTH-1]} - {1'b0, dvs_q};
    // Quotient sign fix is dropped for a zero divisor so it stays all ones.
    assign neg_quo = is_signed_q && (sign1_q ^ sign2_q) && !dzero_q;
    assign neg_rem = is_signed_q && sign1_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            rem_q       <= '0;
            quo_q       <= '0;
            dvs_q       <= '0;
            result_q    <= '0;
            cnt_q       <= '0;
            is_signed_q <= 1'b0;
            is_rem_q    <= 1'b0;
            sign1_q     <= 1'b0;
            sign2_q     <= 1'b0;
            dzero_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            dvs_q       <= dvs_d;
            result_q    <= result_d;
            cnt_q       <= cnt_d;
            is_signed_q <= is_signed_d;
            is_rem_q    <= is_rem_d;
            sign1_q     <= sign1_d;
            sign2_q     <= sign2_d;
            dzero_q     <= dzero_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        dvs_d       = dvs_q;
        result_d    = result_q;
        cnt_d       = cnt_q;
        is_signed_d = is_signed_q;
        is_rem_d    = is_rem_q;
        sign1_d     = sign1_q;
        sign2_d     = sign2_q;
        dzero_d     = dzero_q;
        done        = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start && div_op && !flush) begin
                    is_signed_d = ~alu_op[1];
                    is_rem_d    = alu_op[3];
                    sign1_d     = data1[WIDTH-1];
                    sign2_d     = data2[WIDTH-1];
                    dzero_d     = (data2 == '0);
                    quo_d       = data1;
                    dvs_d       = data2;
                    rem_d       = '0;
`ifdef DIV_ZERO_FAST_EN
                    if (data2 == '0) begin
                        result_d = alu_op[3] ? data1 : '1;
                        state_d  = StFin;
                    end else begin
                        state_d = StLoad;
                    end
`else
                    state_d = StLoad;
`endif
                end
            end
            StLoad: begin
                quo_d   = (is_signed_q && sign1_q) ? -quo_q : quo_q;
                dvs_d   = (is_signed_q && sign2_q) ? -dvs_q : dvs_q;
                rem_d   = '0;
                cnt_d   = CW'(WIDTH - 1);
                state_d = StCalc;
            end
            StCalc: begin
                if (!diff[WIDTH]) begin
                    rem_d = diff[WIDTH-1:0];
                    quo_d = {quo_q[WIDTH-2:0], 1'b1};
                end else begin
                    rem_d = {rem_q[WIDTH-2:0], quo_q[WIDTH-1]};
                    quo_d = {quo_q[WIDTH-2:0], 1'b0};
                end
                if (cnt_q == '0) begin
                    state_d = StFix;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            StFix: begin
                if (is_rem_q) begin
                    result_d = neg_rem ? -rem_q : rem_q;
                end else begin
                    result_d = neg_quo ? -quo_q : quo_q;
                end
                state_d = StFin;
            end
            StFin: begin
                done    = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        // Flush aborts any in-flight op and suppresses DONE and RESULT update.
        if (flush && (state_q != StIdle)) begin
            state_d  = StIdle;
            result_d = result_q;
            done     = 1'b0;
        end
    end

    assign busy   = (state_q != StIdle);
    assign result = result_q;

endmodule

// File: tb/tb_div_sequencer.sv
// Self-checking bench for div_sequencer: directed spec vectors, random ops vs an arithmetic model,
// flush, back-to-back requests and mid-op reset.
module tb_div_sequencer;
    localparam logic [4:0] OP_DIV  = 5'b00101;
    localparam logic [4:0] OP_DIVU = 5'b00111;
    localparam logic [4:0] OP_REM  = 5'b01101;
    localparam logic [4:0] OP_REMU = 5'b01111;
    localparam int         LAT_FULL = 35;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [4:0]  alu_op;
    logic [31:0] data1;
    logic [31:0] data2;
    logic        flush;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int tests_run = 0;
    int failed    = 0;

    div_sequencer #(.WIDTH(32)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .alu_op (alu_op),
        .data1  (data1),
        .data2  (data2),
        .flush  (flush),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    always #5 clk = ~clk;

    // Reference: RISC-V M-extension semantics using wide integer arithmetic.
    function automatic logic [31:0] model(input logic [4:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        longint          sa = $signed(a);
        longint          sb = $signed(b);
        longint unsigned ua = a;
        longint unsigned ub = b;
        longint          r;
        case (op)
            OP_DIV:  r = (b == 0) ? -1 : sa / sb;
            OP_REM:  r = (b == 0) ? sa : sa % sb;
            OP_DIVU: r = (b == 0) ? -1 : longint'(ua / ub);
            default: r = (b == 0) ? longint'(ua) : longint'(ua % ub);
        endcase
        return r[31:0];
    endfunction

    function automatic int exp_lat(input logic [31:0] b);
`ifdef DIV_ZERO_FAST_EN
        return (b == 0) ? 1 : LAT_FULL;
`else
        return LAT_FULL;
`endif
    endfunction

    // Issue one request (accepted at edge N) and follow it to DONE; leaves us at the FIN negedge.
    task automatic run_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int lat, output int bcnt, output logic [31:0] res,
                          output bit got);
        @(negedge clk);
        start = 1'b1; alu_op = op; data1 = a; data2 = b;
        @(negedge clk);
        start = 1'b0;
        lat = 0; bcnt = 0; res = '0; got = 1'b0;
        for (int i = 1; i <= 100; i++) begin
            if (busy) bcnt++;
            if (done) begin
                lat = i; res = result; got = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; flush = 1'b0; alu_op = '0; data1 = '0; data2 = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        tests_run++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== 32'h0) begin
            failed++;
            $display("FAIL reset_state: busy=%b done=%b result=%h, want 0 0 0", busy, done, result);
        end
        reset = 1'b0;
    endtask

    task automatic test_directed();
        logic [4:0]  op[11]  = '{OP_DIV, OP_REM, OP_DIV, OP_REM, OP_DIVU, OP_DIV, OP_REM, OP_REMU,
                                 OP_DIVU, OP_REM, OP_DIV};
        logic [31:0] a[11]   = '{32'd100, 32'd100, 32'hFFFFFFF9, 32'hFFFFFFF9, 32'hFFFFFFF9,
                                 32'h80000000, 32'h80000000, 32'h80000000, 32'd5,
                                 32'hFFFFFFFB, 32'hFFFFFFFB};
        logic [31:0] b[11]   = '{32'd7, 32'd7, 32'd2, 32'd2, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFF,
                                 32'd3, 32'd0, 32'd0, 32'd0};
        logic [31:0] exp[11] = '{32'd14, 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'h7FFFFFFC,
                                 32'h80000000, 32'h0, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFB,
                                 32'hFFFFFFFF};
        int lat, bcnt;
        logic [31:0] res;
        bit got;
        for (int i = 0; i < 11; i++) begin
            run_op(op[i], a[i], b[i], lat, bcnt, res, got);
            tests_run++;
            if (!got || res !== exp[i]) begin
                failed++;
                $display("FAIL directed_result[%0d]: got=%0b result=%h, want %h", i, got, res,
                         exp[i]);
            end
            tests_run++;
            if (lat != exp_lat(b[i]) || bcnt != exp_lat(b[i])) begin
                failed++;
                $display("FAIL directed_latency[%0d]: done_at=%0d busy_cycles=%0d, want %0d", i,
                         lat, bcnt, exp_lat(b[i]));
            end
        end
    endtask

    task automatic test_random();
        logic [4:0]  ops[4] = '{OP_DIV, OP_DIVU, OP_REM, OP_REMU};
        logic [31:0] a, b, exp;
        int lat, bcnt;
        logic [31:0] res;
        bit got;
        for (int i = 0; i < 40; i++) begin
            logic [4:0] op;
            op = ops[$urandom_range(0, 3)];
            a  = $urandom;
            case ($urandom_range(0, 5))
                0:       b = 32'd0;
                1:       b = $urandom_range(1, 15);
                2:       b = 32'hFFFFFFFF;
                3:       b = 32'hFFFFFFF0 | 32'($urandom_range(0, 15));
                default: b = $urandom;
            endcase
            if (i % 8 == 0) a = 32'h80000000;
            exp = model(op, a, b);
            run_op(op, a, b, lat, bcnt, res, got);
            tests_run++;
            if (!got || res !== exp || lat != exp_lat(b)) begin
                failed++;
                $display("FAIL random[%0d] op=%b a=%h b=%h: got=%0b result=%h lat=%0d, want %h lat=%0d",
                         i, op, a, b, got, res, lat, exp, exp_lat(b));
            end
            @(negedge clk);
            tests_run++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                failed++;
                $display("FAIL random_pulse[%0d]: done=%b busy=%b after DONE, want 0 0", i, done,
                         busy);
            end
        end
    endtask

    task automatic test_flush();
        int lat, bcnt;
        logic [31:0] res;
        bit got;
        bit saw_done = 1'b0;
        run_op(OP_REMU, 32'd100, 32'd7, lat, bcnt, res, got);
        // Edge N accepts DIV 100/7.
        @(negedge clk);
        start = 1'b1; alu_op = OP_DIV; data1 = 32'd100; data2 = 32'd7;
        @(negedge clk);                       // cycle N+1
        start = 1'b0;
        repeat (3) @(negedge clk);            // cycle N+4: ignored request sampled at edge N+4
        start = 1'b1; data1 = 32'd9; data2 = 32'd3;
        for (int c = 5; c <= 10; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (done) saw_done = 1'b1;
        end
        flush = 1'b1;                         // cycle N+10
        @(negedge clk);                       // cycle N+11
        flush = 1'b0;
        if (done) saw_done = 1'b1;
        tests_run++;
        if (busy !== 1'b0 || saw_done) begin
            failed++;
            $display("FAIL flush_abort: busy=%b saw_done=%0b, want 0 0", busy, saw_done);
        end
        tests_run++;
        if (result !== 32'd2) begin
            failed++;
            $display("FAIL flush_result_held: result=%h, want 00000002", result);
        end
        start = 1'b1; alu_op = OP_DIV; data1 = 32'd9; data2 = 32'd3;
        @(negedge clk);                       // cycle N+12
        start = 1'b0;
        lat = 0; got = 1'b0;
        for (int i = 1; i <= 100; i++) begin
            if (done) begin
                lat = i; got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        tests_run++;
        if (!got || lat != LAT_FULL || result !== 32'd3) begin
            failed++;
            $display("FAIL flush_restart: got=%0b lat=%0d result=%h, want lat=%0d result=3",
                     got, lat, result, LAT_FULL);
        end
        // Flush and start together in IDLE: start must be dropped.
        @(negedge clk);
        start = 1'b1; flush = 1'b1; alu_op = OP_DIVU; data1 = 32'd50; data2 = 32'd5;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        tests_run++;
        if (busy !== 1'b0) begin
            failed++;
            $display("FAIL flush_start_idle: busy=%b, want 0", busy);
        end
    endtask

    task automatic test_back_to_back();
        int first = -1;
        int second = -1;
        @(negedge clk);
        start = 1'b1; flush = 1'b0; alu_op = OP_DIVU; data1 = 32'd1000; data2 = 32'd10;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (done) begin
                if (first < 0) begin
                    first = c;
                end else begin
                    second = c;
                    break;
                end
            end
        end
        start = 1'b0;
        tests_run++;
        if (first < 0 || second < 0 || (second - first) != LAT_FULL + 1) begin
            failed++;
            $display("FAIL back_to_back_gap: first=%0d second=%0d, want gap %0d", first, second,
                     LAT_FULL + 1);
        end
        tests_run++;
        if (result !== 32'd100) begin
            failed++;
            $display("FAIL back_to_back_result: result=%h, want 00000064", result);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        start = 1'b1; alu_op = OP_DIV; data1 = 32'd100; data2 = 32'd7;
        @(negedge clk);                       // cycle N+1
        start = 1'b0;
        repeat (19) @(negedge clk);           // cycle N+20
        reset = 1'b1;
        @(negedge clk);                       // cycle N+21
        reset = 1'b0;
        tests_run++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== 32'h0) begin
            failed++;
            $display("FAIL reset_mid_op: busy=%b done=%b result=%h, want 0 0 0", busy, done,
                     result);
        end
        start = 1'b1; alu_op = 5'b00000; data1 = 32'd9; data2 = 32'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        tests_run++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== 32'h0) begin
            failed++;
            $display("FAIL non_div_op: busy=%b done=%b result=%h, want 0 0 0", busy, done, result);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_flush();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end

endmodule
